// File: rtl/perm_share_arbiter.sv
// Round-robin arbiter that lends one masked Ascon permutation core to N requesters,
// one full permutation call per grant, and returns the captured result shares.
module perm_share_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned W    = 320,
    parameter int unsigned MAXR = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [5*N-1:0] rounds_i,
    input  logic [W*N-1:0] s0_i,
    input  logic [W*N-1:0] s1_i,
    input  logic [W*N-1:0] s2_i,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done_o,
    output logic [N-1:0]   err_o,
    output logic [W-1:0]   out_0,
    output logic [W-1:0]   out_1,
    output logic [W-1:0]   out_2,
    output logic           p_start,
    output logic [4:0]     p_rounds,
    output logic [W-1:0]   p_s0,
    output logic [W-1:0]   p_s1,
    output logic [W-1:0]   p_s2,
    input  logic           p_done,
    input  logic [W-1:0]   p_out_0,
    input  logic [W-1:0]   p_out_1,
    input  logic [W-1:0]   p_out_2
);
    localparam int unsigned IW = (N > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    logic [4:0]    pick_rounds;
    logic          pick_bad;

    // First requester at or after last+1, wrapping modulo N.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_rounds = rounds_i[32'(pick)*5 +: 5];
        pick_bad    = (pick_rounds == 5'd0) || (32'(pick_rounds) > MAXR);
    end

    // Core-side mux: only the owner's data reaches the core, and only while running.
    always_comb begin
        p_start  = 1'b0;
        p_rounds = 5'(MAXR);
        p_s0     = '0;
        p_s1     = '0;
        p_s2     = '0;
        if (state == RUN) begin
            p_start  = !p_done;
            p_rounds = rounds_i[32'(owner)*5 +: 5];
            p_s0     = s0_i[32'(owner)*W +: W];
            p_s1     = s1_i[32'(owner)*W +: W];
            p_s2     = s2_i[32'(owner)*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= IW'(N-1);
            owner  <= '0;
            gnt    <= '0;
            done_o <= '0;
            err_o  <= '0;
            out_0  <= '0;
            out_1  <= '0;
            out_2  <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        // A rejected requester still moves the pointer so it cannot starve others.
                        last <= pick;
                        if (pick_bad) begin
                            err_o[pick] <= 1'b1;
                        end else begin
                            gnt[pick] <= 1'b1;
                            owner     <= pick;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (p_done) begin
                        out_0         <= p_out_0;
                        out_1         <= p_out_1;
                        out_2         <= p_out_2;
                        done_o[owner] <= 1'b1;
                        gnt           <= '0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perm_share_arbiter.sv
// Bench for perm_share_arbiter: behavioural masked Ascon-p core plus directed call vectors.
module tb_perm_share_arbiter;
    localparam int N = 2;
    localparam int W = 320;
    localparam int CORE_LAT = 13;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [5*N-1:0] rounds_i;
    logic [W*N-1:0] s0_i, s1_i, s2_i;
    logic [N-1:0]   gnt, done_o, err_o;
    logic [W-1:0]   out_0, out_1, out_2;
    logic           p_start;
    logic [4:0]     p_rounds;
    logic [W-1:0]   p_s0, p_s1, p_s2;
    logic           p_done;
    logic [W-1:0]   p_out_0, p_out_1, p_out_2;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] plain [N];
    logic [W-1:0] mask_a, mask_b;

    perm_share_arbiter #(.N(N), .W(W), .MAXR(12)) dut (
        .clk(clk), .rst(rst), .req(req), .rounds_i(rounds_i),
        .s0_i(s0_i), .s1_i(s1_i), .s2_i(s2_i),
        .gnt(gnt), .done_o(done_o), .err_o(err_o),
        .out_0(out_0), .out_1(out_1), .out_2(out_2),
        .p_start(p_start), .p_rounds(p_rounds),
        .p_s0(p_s0), .p_s1(p_s1), .p_s2(p_s2),
        .p_done(p_done), .p_out_0(p_out_0), .p_out_1(p_out_1), .p_out_2(p_out_2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Unmasked Ascon-p reference; x0 sits in bits [63:0].
    function automatic logic [W-1:0] ascon_p(input logic [W-1:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        int c;
        x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192]; x4 = s[319:256];
        for (int i = 0; i < r; i++) begin
            c = 12 - r + i;
            x2 ^= 64'(((15 - c) << 4) | c);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1) ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7) ^ ror(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [W-1:0] rand320();
        logic [W-1:0] r;
        for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural core: latches rounds at start, completes CORE_LAT cycles later with fresh masks.
    logic       core_busy;
    int         core_cnt;
    logic [4:0] core_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_r    <= '0;
            p_done    <= 1'b0;
            p_out_0   <= '0;
            p_out_1   <= '0;
            p_out_2   <= '0;
        end else begin
            p_done <= 1'b0;
            if (!core_busy && p_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 1;
                core_r    <= p_rounds;
            end else if (core_busy) begin
                if (core_cnt == CORE_LAT) begin
                    p_out_0   <= ascon_p(p_s0 ^ p_s1 ^ p_s2, 32'(core_r)) ^ mask_a ^ mask_b;
                    p_out_1   <= mask_a;
                    p_out_2   <= mask_b;
                    p_done    <= 1'b1;
                    core_busy <= 1'b0;
                end
                core_cnt <= core_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_shares(input int i, input logic [W-1:0] p);
        logic [W-1:0] m1, m2;
        m1 = rand320();
        m2 = rand320();
        plain[i] = p;
        s0_i[W*i +: W] = p ^ m1 ^ m2;
        s1_i[W*i +: W] = m1;
        s2_i[W*i +: W] = m2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [4:0] r0;
        logic [4:0] r1;
        bit         exp_err;
        int         exp_g;
        bit         hold;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int bad;
        bit seen;
        logic [4:0] r;
        logic [W-1:0] exp_s0;
        rounds_i = {v.r1, v.r0};
        set_shares(0, rand320());
        set_shares(1, rand320());
        mask_a = rand320();
        mask_b = rand320();
        req = v.req;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            cyc();
            n++;
            if (gnt != '0 || err_o != '0) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_arb_timeout"}, W'(0), W'(1));
            req = '0;
            return;
        end
        if (v.exp_err) begin
            check({tag, "_err"}, W'(err_o), W'(1) << v.exp_g);
            check({tag, "_err_nogrant"}, W'(gnt), W'(0));
            req = '0;
            cyc();
            check({tag, "_err_single"}, W'(err_o), W'(0));
            return;
        end
        r = (v.exp_g == 0) ? v.r0 : v.r1;
        exp_s0 = s0_i[W*v.exp_g +: W];
        check({tag, "_gnt"}, W'(gnt), W'(1) << v.exp_g);
        check({tag, "_p_rounds"}, W'(p_rounds), W'(r));
        check({tag, "_p_s0"}, p_s0, exp_s0);
        n = 0;
        bad = 0;
        while (done_o == '0 && n < 60) begin
            if (p_start !== !p_done || gnt !== N'(1 << v.exp_g)) bad++;
            cyc();
            n++;
        end
        check({tag, "_run_stable"}, W'(bad), W'(0));
        check({tag, "_done"}, W'(done_o), W'(1) << v.exp_g);
        check({tag, "_release"}, W'({gnt, p_start}), W'(0));
        check({tag, "_result"}, out_0 ^ out_1 ^ out_2, ascon_p(plain[v.exp_g], 32'(r)));
        if (!v.hold) req = '0;
        cyc();
        check({tag, "_done_single"}, W'(done_o), W'(0));
    endtask

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic [W-1:0] kat;
        tbl[0] = '{2'b10, 5'd12, 5'd0,  1'b1, 1, 1'b0};
        tbl[1] = '{2'b10, 5'd12, 5'd13, 1'b1, 1, 1'b0};
        tbl[2] = '{2'b10, 5'd12, 5'd8,  1'b0, 1, 1'b0};
        tbl[3] = '{2'b11, 5'd12, 5'd6,  1'b0, 0, 1'b1};
        tbl[4] = '{2'b11, 5'd12, 5'd6,  1'b0, 1, 1'b1};
        tbl[5] = '{2'b11, 5'd12, 5'd6,  1'b0, 0, 1'b1};
        tbl[6] = '{2'b11, 5'd12, 5'd6,  1'b0, 1, 1'b0};
        tbl[7] = '{2'b01, 5'd6,  5'd8,  1'b0, 0, 1'b0};
        tbl[8] = '{2'b10, 5'd6,  5'd12, 1'b0, 1, 1'b0};
        tbl[9] = '{2'b01, 5'd31, 5'd12, 1'b1, 0, 1'b0};

        rst = 1'b1;
        req = '0;
        rounds_i = '0;
        s0_i = '0; s1_i = '0; s2_i = '0;
        mask_a = '0; mask_b = '0;
        repeat (3) cyc();
        check("rst_outputs", W'({gnt, done_o, err_o, p_start}), W'(0));
        check("rst_out_0", out_0, W'(0));
        check("rst_p_rounds", W'(p_rounds), W'(12));
        rst = 1'b0;
        cyc();

        // Single call on the Ascon-Hash IV, 12 rounds, with a known result.
        kat = {64'h348fa5c9d525e140, 64'h43189921b8f8e3e8, 64'hb48a92db98d5da62,
               64'h8bb21831c60f1002, 64'hee9398aadb67f03d};
        rounds_i = {5'd12, 5'd12};
        set_shares(0, {256'h0, 64'h00400c0000000100});
        mask_a = rand320();
        mask_b = rand320();
        req = 2'b01;
        cyc();
        check("iv_gnt_latency", W'(gnt), W'(1));
        check("iv_p_start", W'(p_start), W'(1));
        n = 0;
        bad = 0;
        while (done_o == '0 && n < 60) begin
            if (p_start !== !p_done) bad++;
            cyc();
            n++;
        end
        check("iv_p_start_hold", W'(bad), W'(0));
        check("iv_done", W'(done_o), W'(1));
        check("iv_result", out_0 ^ out_1 ^ out_2, kat);
        req = '0;
        cyc();

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset five cycles into a call.
        rounds_i = {5'd12, 5'd12};
        set_shares(0, rand320());
        req = 2'b01;
        cyc();
        check("mid_gnt", W'(gnt), W'(1));
        repeat (5) cyc();
        rst = 1'b1;
        #1;
        check("mid_rst_drop", W'({gnt, done_o, p_start}), W'(0));
        check("mid_rst_out", out_0 | out_1 | out_2, W'(0));
        cyc();
        rst = 1'b0;
        req = '0;
        bad = 0;
        repeat (20) begin
            cyc();
            if (done_o != '0) bad++;
        end
        check("mid_no_done", W'(bad), W'(0));
        run_vec('{2'b11, 5'd12, 5'd8, 1'b0, 0, 1'b0}, "post_both");
        run_vec('{2'b10, 5'd12, 5'd8, 1'b0, 1, 1'b0}, "post_one");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perm_share_arbiter.md
Name: perm_share_arbiter

Overview:
- Shares one masked (3-share) Ascon permutation core between N independent requesters, e.g. the hash engine and the AEAD engine.
- Round-robin request/grant arbitration; the granted requester holds the core for one full permutation call.
- Muxes the granted requester's state shares and round count onto the core, drives the core's start, and captures the result shares.
- Returns the result with a one-cycle done pulse to the granted requester only.
- Sits between the requester FSMs and the single permutation instance plus its round counter.

Parameters:
- N, 2, number of requesters; legal values 2 to 4.
- W, 320, permutation state width per share.
- MAXR, 12, largest legal round count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  N  per-requester request; held high until that requester's done_o bit pulses.
- rounds_i  in  5*N  per-requester round count; slice i is [5*i+4:5*i].
- s0_i, s1_i, s2_i  in  W*N  per-requester input shares; slice i is [W*i+W-1:W*i].
- gnt  out  N  one-hot grant (registered).
- done_o  out  N  one-cycle completion pulse to the granted requester.
- err_o  out  N  one-cycle pulse: illegal round count was rejected.
- out_0, out_1, out_2  out  W  captured result shares; shared by all requesters, valid from done_o onward.
- p_start  out  1  start to the permutation core.
- p_rounds  out  5  round count to the permutation core.
- p_s0, p_s1, p_s2  out  W  input shares to the permutation core.
- p_done  in  1  core completion flag.
- p_out_0, p_out_1, p_out_2  in  W  core result shares.

Behaviour:

Reset (asynchronous, active-high):
- state=IDLE; gnt=0; done_o=0; err_o=0; out_0/1/2=0.
- Round-robin pointer last=N-1, so requester 0 has first priority.
- Reset mid-operation abandons the call: no done_o, outputs return to 0, and p_start drops immediately.

State IDLE:
- If req is nonzero, select the first set bit scanning from last+1 upward, wrapping modulo N. Call it g.
- If rounds_i[g] is 0 or greater than MAXR:
  - pulse err_o[g] the next cycle; no grant.
  - last<=g, so a persistently bad requester cannot starve the others.
  - stay in IDLE.
- Otherwise: gnt<=one-hot(g), last<=g, go to RUN. Grant appears the cycle after req is first seen high (latency 1).

State RUN:
- p_s0/p_s1/p_s2 and p_rounds are driven combinationally from requester g's slices.
- p_start = !p_done.
- Requester g must hold its inputs stable while gnt[g] is high; the arbiter does not register them.
- When p_done=1:
  - out_0/1/2 <= p_out_0/1/2.
  - done_o[g] pulses the following cycle.
  - gnt<=0; go to RELEASE.

State RELEASE:
- Lasts exactly one cycle.
- p_start=0 and the p_* data outputs are 0, so the core and round counter see start low before the next call.
- Go to IDLE.

Outside RUN:
- p_start=0; p_s*=0; p_rounds=MAXR.

Other rules:
- Throughput: minimum 3 cycles of arbitration overhead per call (IDLE, grant, RELEASE) plus the core latency.
- A req bit deasserted while granted is ignored; the call runs to completion and done_o still pulses.
- A requester still asserting req in RELEASE re-arbitrates in IDLE with the lowest priority (last=g).
- With all N requesting continuously, grants rotate 0,1,...,N-1,0,...
- out_0/1/2 hold their value until the next capture.
- gnt, done_o and err_o are always one-hot or zero; never two bits set at once.

Test Plan:
- Single call: N=2, req[0]=1, rounds_i[0]=12, core done after 13 cycles -> gnt=01 one cycle after req; p_start high until p_done; done_o=01 pulse; out_0/1/2 equal the core model result for the IV state.
- Contention: req=11 held across four calls -> grant order 0,1,0,1; exactly one done_o pulse per call; p_start low for at least one cycle between calls.
- Illegal rounds: rounds_i[1]=0, then 13, with req[1] alone -> err_o=10 pulse each time, gnt stays 0; then rounds_i[1]=8 -> normal grant and p_rounds=8.
- Reset mid-RUN: assert rst 5 cycles into a call -> gnt, p_start and done_o drop immediately, out_0/1/2=0; after release, req[1]=1 alone is granted first, and with req=11 requester 0 is granted first.
- Share recombination: random share inputs with XOR-fixed plaintext -> out_0^out_1^out_2 matches the unmasked Ascon-p reference for 6, 8 and 12 rounds.
